// File: rtl/alu_share_sched_pkg.sv
// Shared types for the ALU time-share scheduler: ALU control codes and FSM states.
package alu_share_sched_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_XOR  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_AND  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001,
    ALU_BEQ  = 4'b1010,
    ALU_BNE  = 4'b1011,
    ALU_BLT  = 4'b1100,
    ALU_BGE  = 4'b1101,
    ALU_BLTU = 4'b1110,
    ALU_BGEU = 4'b1111
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } sched_state_e;

  // Branch codes occupy the top of the encoding space.
  function automatic logic is_branch(input logic [3:0] code);
    return code >= 4'b1010;
  endfunction

endpackage

// File: rtl/alu_share_sched_if.sv
// Requester-side request/response bundle of the ALU scheduler.
// Handshake: a request transfers on a cycle where req_valid[i] & req_ready[i]; a response
// transfers where rsp_valid[i] & rsp_ready[i]. Valid may drop before ready; data is sampled
// only on the transfer cycle; rsp_result/rsp_flag are stable while any rsp_valid is high.
interface alu_share_sched_if #(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = 32
);
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ-1:0][3:0]      req_op;
  logic [NUM_REQ-1:0][XLEN-1:0] req_a;
  logic [NUM_REQ-1:0][XLEN-1:0] req_b;
  logic [NUM_REQ-1:0]           rsp_valid;
  logic [NUM_REQ-1:0]           rsp_ready;
  logic [XLEN-1:0]              rsp_result;
  logic                         rsp_flag;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_flag
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_flag
  );
endinterface

// File: rtl/alu_share_sched_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after the pointer.
module alu_share_sched_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   grant_idx,
  output logic               any_grant
);

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      int k;
      k = (int'(ptr) + i) % NUM_REQ;
      if (!any_grant && req[k]) begin
        any_grant = 1'b1;
        grant[k]  = 1'b1;
        grant_idx = PTR_W'(k);
      end
    end
  end

endmodule

// File: rtl/alu_share_sched.sv
// Time-shares one combinational ALU between NUM_REQ requesters: round-robin accept,
// one EXEC cycle driving the ALU, then a registered result held until the winner takes it.
module alu_share_sched
  import alu_share_sched_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = 32,
  parameter int CNT_W   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_share_sched_if.slave    bus,
  output logic [3:0]          alu_op,
  output logic [XLEN-1:0]     alu_a,
  output logic [XLEN-1:0]     alu_b,
  input  logic [XLEN-1:0]     alu_result,
  input  logic                alu_flag,
  output logic                busy,
  output logic [CNT_W-1:0]    op_count,
  output sched_state_e        dbg_state
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  sched_state_e       state;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   gnt_idx;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [XLEN-1:0]    rsp_result_q;
  logic               rsp_flag_q;

  logic               rsp_hs;
  logic               accept_win;
  logic [PTR_W-1:0]   arb_ptr;
  logic [NUM_REQ-1:0] arb_req;
  logic [NUM_REQ-1:0] arb_grant;
  logic [PTR_W-1:0]   arb_idx;
  logic               arb_any;

  function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] i);
    return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  // rsp_valid_q is one-hot on the owner, so a ready on any other index cannot complete.
  assign rsp_hs     = (state == RESP) && ((rsp_valid_q & bus.rsp_ready) != '0);
  assign accept_win = (state == IDLE) || rsp_hs;
  // On the response handshake the pointer has already moved past the finishing owner.
  assign arb_ptr    = rsp_hs ? next_idx(gnt_idx) : ptr;
  assign arb_req    = bus.req_valid & {NUM_REQ{accept_win}};

  alu_share_sched_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .req       (arb_req),
    .ptr       (arb_ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_grant (arb_any)
  );

  // Gated by reset so that no accept is signalled while the block is held in reset.
  assign bus.req_ready  = arb_grant & {NUM_REQ{rst_n}};
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_flag   = rsp_flag_q;
  assign busy           = (state != IDLE);
  assign dbg_state      = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ptr          <= '0;
      gnt_idx      <= '0;
      alu_op       <= ALU_ADD;
      alu_a        <= '0;
      alu_b        <= '0;
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
      rsp_flag_q   <= 1'b0;
      op_count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_any) state <= EXEC;
        end
        EXEC: begin
          rsp_result_q <= alu_result;
          rsp_flag_q   <= alu_flag & is_branch(alu_op);
          rsp_valid_q  <= NUM_REQ'(1) << gnt_idx;
          alu_op       <= ALU_ADD;
          alu_a        <= '0;
          alu_b        <= '0;
          state        <= RESP;
        end
        RESP: begin
          if (rsp_hs) begin
            rsp_valid_q <= '0;
            op_count    <= op_count + 1'b1;
            ptr         <= next_idx(gnt_idx);
            state       <= arb_any ? EXEC : IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // arb_any can only be high in IDLE or on the RESP handshake, never alongside EXEC.
      if (arb_any) begin
        gnt_idx <= arb_idx;
        alu_op  <= bus.req_op[arb_idx];
        alu_a   <= bus.req_a[arb_idx];
        alu_b   <= bus.req_b[arb_idx];
      end
    end
  end

endmodule

// File: tb/tb_alu_share_sched.sv
// Bench for alu_share_sched: vector table, directed corner sequences, and a randomized run
// checked against a transaction-level model of the scheduler.
module tb_alu_share_sched;
  import alu_share_sched_pkg::*;

  localparam int NREQ = 2;
  localparam int XL   = 32;
  localparam int CW   = 4;

  logic          clk;
  logic          rst_n;
  logic [3:0]    alu_op;
  logic [XL-1:0] alu_a, alu_b, alu_result;
  logic          alu_flag;
  logic          busy;
  logic [CW-1:0] op_count;
  sched_state_e  dbg_state;

  int total = 0;
  int bad   = 0;

  alu_share_sched_if #(.NUM_REQ(NREQ), .XLEN(XL)) bus ();

  alu_share_sched #(.NUM_REQ(NREQ), .XLEN(XL), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .alu_flag   (alu_flag),
    .busy       (busy),
    .op_count   (op_count),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: {flag, result}
  function automatic logic [XL:0] alu_model(input logic [3:0] op, input logic [XL-1:0] a,
                                            input logic [XL-1:0] b);
    logic [XL-1:0] r;
    logic f;
    f = ^(a ^ b);
    case (op)
      4'd0:  r = a + b;
      4'd1:  r = a - b;
      4'd2:  r = a ^ b;
      4'd3:  r = a | b;
      4'd4:  r = a & b;
      4'd5:  r = a << b[4:0];
      4'd6:  r = a >> b[4:0];
      4'd7:  r = $unsigned($signed(a) >>> b[4:0]);
      4'd8:  begin f = ($signed(a) < $signed(b)); r = {31'd0, f}; end
      4'd9:  begin f = (a < b); r = {31'd0, f}; end
      4'd10: begin f = (a == b); r = a - b; end
      4'd11: begin f = (a != b); r = a - b; end
      4'd12: begin f = ($signed(a) < $signed(b)); r = a - b; end
      4'd13: begin f = ($signed(a) >= $signed(b)); r = a - b; end
      4'd14: begin f = (a < b); r = a - b; end
      default: begin f = (a >= b); r = a - b; end
    endcase
    return {f, r};
  endfunction

  assign {alu_flag, alu_result} = alu_model(alu_op, alu_a, alu_b);

  // ---------------- helpers / driver tasks ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = '0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drive_req(input int idx, input logic [3:0] op, input logic [XL-1:0] a,
                           input logic [XL-1:0] b);
    bus.req_valid[idx] = 1'b1;
    bus.req_op[idx]    = op;
    bus.req_a[idx]     = a;
    bus.req_b[idx]     = b;
  endtask

  // Single op from an idle scheduler, with cycle-exact latency checks.
  task automatic do_op(input string name, input int idx, input logic [3:0] op,
                       input logic [XL-1:0] a, input logic [XL-1:0] b,
                       input logic [XL-1:0] exp_res, input logic exp_flg);
    logic [1:0] oh;
    oh = 2'(1 << idx);
    tick();
    drive_req(idx, op, a, b);
    #1;
    check({name, " req_ready"}, bus.req_ready, oh);
    tick();
    bus.req_valid = '0;
    #1;
    check({name, " exec alu_op"}, alu_op, op);
    check({name, " exec alu_a"}, alu_a, a);
    check({name, " exec rsp_valid"}, bus.rsp_valid, 2'b00);
    tick();
    check({name, " rsp_valid"}, bus.rsp_valid, oh);
    check({name, " rsp_result"}, bus.rsp_result, exp_res);
    check({name, " rsp_flag"}, bus.rsp_flag, exp_flg);
    bus.rsp_ready = oh;
    tick();
    bus.rsp_ready = '0;
    #1;
    check({name, " after rsp_valid"}, bus.rsp_valid, 2'b00);
    check({name, " after busy"}, busy, 1'b0);
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (p + k) % NREQ;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    int            idx;
    logic [3:0]    op;
    logic [XL-1:0] a;
    logic [XL-1:0] b;
    logic [XL-1:0] res;
    logic          flg;
  } vec_t;

  vec_t vecs[12];

  // ---------------- scoreboard ----------------
  typedef struct {
    int            idx;
    logic [3:0]    op;
    logic [XL-1:0] a;
    logic [XL-1:0] b;
    int            acc;
  } info_t;

  logic [XL:0] exp_q[$];
  info_t       info_q[$];

  initial begin
    logic [1:0]    exp_rr_seq[8];
    logic [XL-1:0] held;
    int            m_ptr, m_count, g;
    logic [1:0]    exp_rv, exp_rr;
    logic          hs;
    logic [XL:0]   m;
    info_t         inf;

    vecs[0]  = '{0, 4'h0, 32'd5,        32'd7,  32'd12,       1'b0};
    vecs[1]  = '{1, 4'hA, 32'd9,        32'd9,  32'd0,        1'b1};
    vecs[2]  = '{1, 4'hB, 32'd9,        32'd9,  32'd0,        1'b0};
    vecs[3]  = '{0, 4'h8, 32'd3,        32'd5,  32'd1,        1'b0};
    vecs[4]  = '{1, 4'h1, 32'd10,       32'd3,  32'd7,        1'b0};
    vecs[5]  = '{0, 4'h2, 32'hF0,       32'h0F, 32'hFF,       1'b0};
    vecs[6]  = '{1, 4'h7, 32'h80000000, 32'd4,  32'hF8000000, 1'b0};
    vecs[7]  = '{0, 4'hC, 32'hFFFFFFFF, 32'd1,  32'hFFFFFFFE, 1'b1};
    vecs[8]  = '{1, 4'hE, 32'hFFFFFFFF, 32'd1,  32'hFFFFFFFE, 1'b0};
    vecs[9]  = '{0, 4'hF, 32'hFFFFFFFF, 32'd1,  32'hFFFFFFFE, 1'b1};
    vecs[10] = '{1, 4'h3, 32'd1,        32'd0,  32'd1,        1'b0};
    vecs[11] = '{0, 4'h5, 32'd1,        32'd5,  32'd32,       1'b0};

    // ---- reset values ----
    clear_inputs();
    rst_n = 1'b0;
    #2;
    check("reset req_ready", bus.req_ready, 2'b00);
    check("reset rsp_valid", bus.rsp_valid, 2'b00);
    check("reset rsp_result", bus.rsp_result, 32'd0);
    check("reset rsp_flag", bus.rsp_flag, 1'b0);
    check("reset alu_op", alu_op, 4'b0000);
    check("reset alu_a", alu_a, 32'd0);
    check("reset alu_b", alu_b, 32'd0);
    check("reset busy", busy, 1'b0);
    check("reset op_count", op_count, 4'd0);
    check("reset state", dbg_state, IDLE);
    apply_reset();

    // ---- table of single ops ----
    for (int i = 0; i < 12; i++)
      do_op($sformatf("vec%0d", i), vecs[i].idx, vecs[i].op, vecs[i].a, vecs[i].b,
            vecs[i].res, vecs[i].flg);
    check("table op_count", op_count, 4'd12);

    // ---- contention: alternate grants, one op per 2 cycles ----
    apply_reset();
    exp_rr_seq = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
    tick();
    drive_req(0, 4'h1, 32'd10, 32'h0);
    bus.req_b[0] = 32'd3;
    drive_req(1, 4'h2, 32'hF0, 32'h0F);
    bus.rsp_ready = 2'b11;
    for (int c = 0; c < 8; c++) begin
      #1;
      check($sformatf("cont c%0d req_ready", c), bus.req_ready, exp_rr_seq[c]);
      check($sformatf("cont c%0d op_count", c), op_count, (c < 3) ? 0 : (c - 1) / 2);
      if (c == 2 || c == 6) begin
        check($sformatf("cont c%0d rsp_valid", c), bus.rsp_valid, 2'b01);
        check($sformatf("cont c%0d result", c), bus.rsp_result, 32'd7);
      end
      if (c == 4) begin
        check("cont c4 rsp_valid", bus.rsp_valid, 2'b10);
        check("cont c4 result", bus.rsp_result, 32'hFF);
      end
      tick();
    end
    bus.req_valid = '0;
    tick();
    tick();
    check("cont drained busy", busy, 1'b0);
    check("cont op_count", op_count, 4'd4);

    // ---- backpressure and wrong-index ready ----
    apply_reset();
    tick();
    drive_req(0, 4'h0, 32'd1, 32'd2);
    #1;
    check("bp accept", bus.req_ready, 2'b01);
    tick();
    drive_req(1, 4'h2, 32'h33, 32'h0F);
    bus.rsp_ready = 2'b10;
    tick();
    held = bus.rsp_result;
    check("bp result", held, 32'd3);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp c%0d rsp_valid", c), bus.rsp_valid, 2'b01);
      check($sformatf("bp c%0d req_ready", c), bus.req_ready, 2'b00);
      check($sformatf("bp c%0d result stable", c), bus.rsp_result, held);
      check($sformatf("bp c%0d op_count", c), op_count, 4'd0);
      tick();
    end
    bus.rsp_ready = 2'b01;
    #1;
    check("bp release grants req1", bus.req_ready, 2'b10);
    tick();
    bus.req_valid = '0;
    bus.rsp_ready = 2'b11;
    #1;
    check("bp op_count", op_count, 4'd1);
    check("bp req1 exec op", alu_op, 4'h2);
    check("bp req1 exec a", alu_a, 32'h33);
    tick();
    check("bp req1 result", bus.rsp_result, 32'h3C);
    check("bp req1 rsp_valid", bus.rsp_valid, 2'b10);
    tick();
    bus.rsp_ready = '0;

    // ---- async reset mid-RESP drops the transaction and the pointer ----
    apply_reset();
    do_op("pre-rst", 0, 4'h0, 32'd1, 32'd1, 32'd2, 1'b0);
    tick();
    drive_req(0, 4'h0, 32'd4, 32'd4);
    drive_req(1, 4'h0, 32'd6, 32'd6);
    #1;
    check("rst pre grant", bus.req_ready, 2'b10);
    tick();
    tick();
    check("rst in RESP", bus.rsp_valid, 2'b10);
    rst_n = 1'b0;
    #1;
    check("rst mid rsp_valid", bus.rsp_valid, 2'b00);
    check("rst mid req_ready", bus.req_ready, 2'b00);
    check("rst mid busy", busy, 1'b0);
    check("rst mid alu_op", alu_op, 4'd0);
    check("rst mid result", bus.rsp_result, 32'd0);
    check("rst mid op_count", op_count, 4'd0);
    tick();
    rst_n = 1'b1;
    bus.req_valid = '0;
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("rst post c%0d rsp_valid", c), bus.rsp_valid, 2'b00);
    end
    bus.req_valid = 2'b11;
    #1;
    check("rst pointer back to 0", bus.req_ready, 2'b01);
    bus.req_valid = '0;
    tick();
    tick();
    bus.rsp_ready = 2'b11;
    tick();
    bus.rsp_ready = '0;

    // ---- counter wrap ----
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      if (i == 15) check("wrap before last", op_count, 4'd15);
      do_op($sformatf("wrap%0d", i), i % 2, 4'h0, i, 32'd1, i + 1, 1'b0);
    end
    check("wrap op_count", op_count, 4'd0);

    // ---- randomized run against the transaction model ----
    apply_reset();
    m_ptr   = 0;
    m_count = 0;
    tick();
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < NREQ; i++) begin
        logic [XL-1:0] a, b;
        int sel;
        a   = $urandom;
        sel = $urandom_range(0, 3);
        b   = (sel == 0) ? a : (sel == 1) ? XL'($urandom_range(0, 40)) : $urandom;
        bus.req_valid[i] = ($urandom_range(0, 99) < 60);
        bus.req_op[i]    = 4'($urandom_range(0, 15));
        bus.req_a[i]     = a;
        bus.req_b[i]     = b;
        bus.rsp_ready[i] = ($urandom_range(0, 99) < 70);
      end
      #1;
      exp_rv = 2'b00;
      if (info_q.size() > 0) begin
        if (cyc >= info_q[0].acc + 2) exp_rv = 2'(1 << info_q[0].idx);
        if (cyc == info_q[0].acc + 1) begin
          check("rnd exec alu_op", alu_op, info_q[0].op);
          check("rnd exec alu_a", alu_a, info_q[0].a);
          check("rnd exec alu_b", alu_b, info_q[0].b);
        end else begin
          check("rnd idle alu_op", alu_op, 4'd0);
        end
      end else begin
        check("rnd idle alu_a", alu_a, 32'd0);
      end
      check("rnd rsp_valid", bus.rsp_valid, exp_rv);
      check("rnd busy", busy, info_q.size() > 0);
      check("rnd op_count", op_count, m_count % 16);
      hs = (exp_rv & bus.rsp_ready) != 2'b00;
      if (hs) begin
        m = exp_q.pop_front();
        inf = info_q.pop_front();
        check("rnd rsp_result", bus.rsp_result, m[XL-1:0]);
        check("rnd rsp_flag", bus.rsp_flag, m[XL] & (inf.op >= 4'd10));
        m_count++;
        m_ptr = (inf.idx + 1) % NREQ;
      end
      exp_rr = 2'b00;
      g = -1;
      if (info_q.size() == 0) begin
        g = rr_pick(bus.req_valid, m_ptr);
        if (g >= 0) exp_rr = 2'(1 << g);
      end
      check("rnd req_ready", bus.req_ready, exp_rr);
      if (g >= 0) begin
        exp_q.push_back(alu_model(bus.req_op[g], bus.req_a[g], bus.req_b[g]));
        info_q.push_back('{g, bus.req_op[g], bus.req_a[g], bus.req_b[g], cyc});
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
